// File: rtl/vec_isa_pkg.sv
// rtl/vec_isa_pkg.sv - opcodes, sequencer state and beat-count helpers for the vector issue sequencer
package vec_isa_pkg;

   localparam logic [3:0] OP_VADD = 4'b0000;
   localparam logic [3:0] OP_VDOT = 4'b0001;
   localparam logic [3:0] OP_SMUL = 4'b0010;
   localparam logic [3:0] OP_SST  = 4'b0011;
   localparam logic [3:0] OP_VLD  = 4'b0100;
   localparam logic [3:0] OP_VST  = 4'b0101;
   localparam logic [3:0] OP_SLL  = 4'b0110;
   localparam logic [3:0] OP_SLH  = 4'b0111;
   localparam logic [3:0] OP_J    = 4'b1000;
   localparam logic [3:0] OP_NOP  = 4'b1111;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } state_e;

   // Vector ops walk every element; scalar/control ops issue a single beat.
   function automatic int beat_count(input logic [3:0] op, input int vlen);
      case (op)
         OP_VADD, OP_VDOT, OP_SMUL, OP_VLD, OP_VST: beat_count = vlen;
         OP_SST, OP_SLL, OP_SLH, OP_J:              beat_count = 1;
         default:                                   beat_count = 0;
      endcase
   endfunction

   function automatic logic is_illegal(input logic [3:0] op);
      is_illegal = (op >= 4'b1001) && (op <= 4'b1110);
   endfunction

endpackage

// File: rtl/vec_field_dec.sv
// rtl/vec_field_dec.sv - combinational operand field and writeback enable extraction
module vec_field_dec
   import vec_isa_pkg::*;
(
   input  logic [15:0] instr_i,
   output logic [3:0]  opcode_o,
   output logic [2:0]  dst_o,
   output logic [2:0]  a1_o,
   output logic [2:0]  a2_o,
   output logic [5:0]  offset_o,
   output logic [7:0]  imm_o,
   output logic        v_en_o,
   output logic        s_en_o,
   output logic        illegal_o,
   output logic        nop_o
);

   always_comb begin
      opcode_o  = instr_i[15:12];
      dst_o     = 3'd0;
      a1_o      = 3'd0;
      a2_o      = 3'd0;
      offset_o  = 6'd0;
      imm_o     = 8'd0;
      v_en_o    = 1'b0;
      s_en_o    = 1'b0;
      illegal_o = is_illegal(instr_i[15:12]);
      nop_o     = (instr_i[15:12] == OP_NOP);
      case (instr_i[15:12])
         OP_VADD, OP_VDOT, OP_SMUL: begin
            dst_o = instr_i[11:9];
            a1_o  = instr_i[8:6];
            a2_o  = instr_i[5:3];
         end
         OP_VLD: begin
            dst_o    = instr_i[11:9];
            a1_o     = instr_i[8:6];
            offset_o = instr_i[5:0];
         end
         // Stores read the data register from the rd/rs slot.
         OP_VST, OP_SST: begin
            a1_o     = instr_i[8:6];
            a2_o     = instr_i[11:9];
            offset_o = instr_i[5:0];
         end
         OP_SLL, OP_SLH: begin
            dst_o = instr_i[11:9];
            a1_o  = instr_i[11:9];
            imm_o = instr_i[7:0];
         end
         OP_J: imm_o = instr_i[7:0];
         default: ;
      endcase
      case (instr_i[15:12])
         OP_VADD, OP_VLD, OP_SMUL: v_en_o = 1'b1;
         OP_VDOT, OP_SLL, OP_SLH:  s_en_o = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/vec_issue_seq.sv
// rtl/vec_issue_seq.sv - accepts instructions and issues them to execute as per-element beats
module vec_issue_seq
   import vec_isa_pkg::*;
#(
   parameter int VLEN = 16,
   parameter int NREG = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      instr_valid,
   input  logic [15:0]               instr,
   output logic                      instr_ready,
   output logic                      exe_valid,
   input  logic                      exe_ready,
   output logic [3:0]                functype,
   output logic [$clog2(NREG)-1:0]   dst_addr,
   output logic [$clog2(NREG)-1:0]   addr1,
   output logic [$clog2(NREG)-1:0]   addr2,
   output logic [5:0]                offset,
   output logic [7:0]                immediate,
   output logic                      v_en,
   output logic                      s_en,
   output logic [$clog2(VLEN)-1:0]   elem_idx,
   output logic                      first,
   output logic                      last,
   output logic                      busy,
   output logic                      illegal
);

   localparam int IW = $clog2(VLEN);
   localparam int AW = $clog2(NREG);

   logic [3:0] dec_op;
   logic [2:0] dec_dst, dec_a1, dec_a2;
   logic [5:0] dec_offset;
   logic [7:0] dec_imm;
   logic       dec_v_en, dec_s_en, dec_illegal, dec_nop;

   vec_field_dec u_dec (
      .instr_i   (instr),
      .opcode_o  (dec_op),
      .dst_o     (dec_dst),
      .a1_o      (dec_a1),
      .a2_o      (dec_a2),
      .offset_o  (dec_offset),
      .imm_o     (dec_imm),
      .v_en_o    (dec_v_en),
      .s_en_o    (dec_s_en),
      .illegal_o (dec_illegal),
      .nop_o     (dec_nop)
   );

   state_e        state_q, state_d;
   logic [3:0]    functype_q, functype_d;
   logic [AW-1:0] dst_q, dst_d, a1_q, a1_d, a2_q, a2_d;
   logic [5:0]    offset_q, offset_d;
   logic [7:0]    imm_q, imm_d;
   logic          v_en_q, v_en_d, s_en_q, s_en_d;
   logic [IW-1:0] elem_q, elem_d, last_idx_q, last_idx_d;
   logic          illegal_q, illegal_d;

   logic in_issue, is_last, handshake, accept, start;

   assign in_issue    = (state_q == ST_ISSUE);
   assign is_last     = in_issue && (elem_q == last_idx_q);
   assign handshake   = in_issue && exe_ready;
   // A new instruction may only slip in on the cycle the final beat is consumed.
   assign instr_ready = !in_issue || (handshake && is_last);
   assign accept      = instr_valid && instr_ready;
   assign start       = accept && !dec_illegal && !dec_nop;

   always_comb begin
      state_d    = state_q;
      functype_d = functype_q;
      dst_d      = dst_q;
      a1_d       = a1_q;
      a2_d       = a2_q;
      offset_d   = offset_q;
      imm_d      = imm_q;
      v_en_d     = v_en_q;
      s_en_d     = s_en_q;
      elem_d     = elem_q;
      last_idx_d = last_idx_q;
      illegal_d  = accept && dec_illegal;
      if (start) begin
         state_d    = ST_ISSUE;
         functype_d = dec_op;
         dst_d      = AW'(dec_dst);
         a1_d       = AW'(dec_a1);
         a2_d       = AW'(dec_a2);
         offset_d   = dec_offset;
         imm_d      = dec_imm;
         v_en_d     = dec_v_en;
         s_en_d     = dec_s_en;
         elem_d     = '0;
         last_idx_d = IW'(beat_count(dec_op, VLEN) - 1);
      end else if (handshake) begin
         if (is_last) begin
            state_d = ST_IDLE;
         end else begin
            elem_d = elem_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         functype_q <= '0;
         dst_q      <= '0;
         a1_q       <= '0;
         a2_q       <= '0;
         offset_q   <= '0;
         imm_q      <= '0;
         v_en_q     <= 1'b0;
         s_en_q     <= 1'b0;
         elem_q     <= '0;
         last_idx_q <= '0;
         illegal_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         functype_q <= functype_d;
         dst_q      <= dst_d;
         a1_q       <= a1_d;
         a2_q       <= a2_d;
         offset_q   <= offset_d;
         imm_q      <= imm_d;
         v_en_q     <= v_en_d;
         s_en_q     <= s_en_d;
         elem_q     <= elem_d;
         last_idx_q <= last_idx_d;
         illegal_q  <= illegal_d;
      end
   end

   assign busy      = in_issue;
   assign exe_valid = in_issue;
   assign first     = in_issue && (elem_q == '0);
   assign last      = is_last;
   assign functype  = functype_q;
   assign dst_addr  = dst_q;
   assign addr1     = a1_q;
   assign addr2     = a2_q;
   assign offset    = offset_q;
   assign immediate = imm_q;
   assign v_en      = v_en_q && in_issue;
   assign s_en      = s_en_q && in_issue;
   assign elem_idx  = elem_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_vec_issue_seq.sv
// tb/tb_vec_issue_seq.sv - directed self-checking bench for vec_issue_seq
module tb_vec_issue_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_valid = 1'b0;
   logic [15:0] instr = 16'h0000;
   logic        instr_ready;
   logic        exe_valid;
   logic        exe_ready = 1'b0;
   logic [3:0]  functype;
   logic [2:0]  dst_addr, addr1, addr2;
   logic [5:0]  offset;
   logic [7:0]  immediate;
   logic        v_en, s_en;
   logic [3:0]  elem_idx;
   logic        first, last, busy, illegal;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   vec_issue_seq #(.VLEN(16), .NREG(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .exe_valid   (exe_valid),
      .exe_ready   (exe_ready),
      .functype    (functype),
      .dst_addr    (dst_addr),
      .addr1       (addr1),
      .addr2       (addr2),
      .offset      (offset),
      .immediate   (immediate),
      .v_en        (v_en),
      .s_en        (s_en),
      .elem_idx    (elem_idx),
      .first       (first),
      .last        (last),
      .busy        (busy),
      .illegal     (illegal)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int hs;
      int cyc;

      // Reset state
      step();
      step();
      chk("rst_exe_valid", exe_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_illegal", illegal, 0);
      chk("rst_elem", elem_idx, 0);
      chk("rst_v_en", v_en, 0);
      chk("rst_dst", dst_addr, 0);
      rst_n = 1'b1;
      step();
      chk("rst_instr_ready", instr_ready, 1);

      // VADD 0x0A98, 16 beats at full throughput
      instr = 16'h0A98; instr_valid = 1'b1; exe_ready = 1'b1;
      step();
      instr_valid = 1'b0;
      chk("vadd_first", first, 1);
      chk("vadd_dst", dst_addr, 5);
      chk("vadd_a1", addr1, 2);
      chk("vadd_a2", addr2, 3);
      chk("vadd_v_en", v_en, 1);
      chk("vadd_s_en", s_en, 0);
      chk("vadd_func", functype, 4'h0);
      for (int i = 0; i < 16; i++) begin
         chk("vadd_valid", exe_valid, 1);
         chk("vadd_elem", elem_idx, i);
         chk("vadd_last", last, (i == 15));
         if (i == 15) chk("vadd_ready_last", instr_ready, 1);
         else if (i == 4) chk("vadd_ready_mid", instr_ready, 0);
         step();
      end
      chk("vadd_busy_after", busy, 0);
      chk("vadd_valid_after", exe_valid, 0);

      // SLL 0x6A7F, single beat
      instr = 16'h6A7F; instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
      chk("sll_valid", exe_valid, 1);
      chk("sll_first", first, 1);
      chk("sll_last", last, 1);
      chk("sll_elem", elem_idx, 0);
      chk("sll_dst", dst_addr, 5);
      chk("sll_a1", addr1, 5);
      chk("sll_a2", addr2, 0);
      chk("sll_imm", immediate, 8'h7F);
      chk("sll_s_en", s_en, 1);
      chk("sll_v_en", v_en, 0);
      step();
      chk("sll_busy_after", busy, 0);

      // VLD 0x42EA then SST 0x3D05 back-to-back
      instr = 16'h42EA; instr_valid = 1'b1;
      step();
      chk("vld_dst", dst_addr, 1);
      chk("vld_a1", addr1, 3);
      chk("vld_offset", offset, 6'h2A);
      chk("vld_v_en", v_en, 1);
      instr = 16'h3D05;
      for (int i = 0; i < 16; i++) begin
         chk("vld_elem", elem_idx, i);
         chk("vld_func", functype, 4'h4);
         if (i == 3) chk("vld_ready_mid", instr_ready, 0);
         if (i == 15) chk("vld_ready_last", instr_ready, 1);
         step();
      end
      instr_valid = 1'b0;
      chk("sst_valid", exe_valid, 1);
      chk("sst_func", functype, 4'h3);
      chk("sst_first", first, 1);
      chk("sst_last", last, 1);
      chk("sst_a1", addr1, 4);
      chk("sst_a2", addr2, 6);
      chk("sst_dst", dst_addr, 0);
      chk("sst_offset", offset, 6'h05);
      chk("sst_v_en", v_en, 0);
      step();
      chk("sst_busy_after", busy, 0);

      // VST 0x55CC with exe_ready alternating 1,0
      instr = 16'h55CC; instr_valid = 1'b1; exe_ready = 1'b0;
      step();
      instr_valid = 1'b0;
      hs = 0;
      cyc = 0;
      while (busy && cyc < 100) begin
         chk("vst_elem", elem_idx, hs);
         chk("vst_a1", addr1, 7);
         chk("vst_a2", addr2, 2);
         chk("vst_offset", offset, 6'h0C);
         chk("vst_last", last, (hs == 15));
         exe_ready = (cyc % 2 == 0);
         #1;
         if (hs == 15 && !exe_ready) chk("vst_ready_stall_last", instr_ready, 0);
         if (exe_ready) hs++;
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("vst_timeout", (cyc < 100), 1);
      chk("vst_handshakes", hs, 16);
      exe_ready = 1'b1;

      // Illegal 0x9123 followed by NOP 0xF000
      instr = 16'h9123; instr_valid = 1'b1;
      step();
      instr = 16'hF000;
      chk("ill_pulse", illegal, 1);
      chk("ill_valid", exe_valid, 0);
      chk("ill_busy", busy, 0);
      step();
      instr_valid = 1'b0;
      chk("nop_illegal", illegal, 0);
      chk("nop_valid", exe_valid, 0);
      chk("nop_busy", busy, 0);
      step();
      chk("nop_valid2", exe_valid, 0);
      chk("nop_illegal2", illegal, 0);

      // VDOT 0x1660 with reset asserted at beat 7
      instr = 16'h1660; instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
      chk("vdot_dst", dst_addr, 3);
      chk("vdot_s_en", s_en, 1);
      for (int i = 0; i < 7; i++) step();
      chk("vdot_elem7", elem_idx, 7);
      #1;
      rst_n = 1'b0;
      #1;
      chk("vdot_rst_valid", exe_valid, 0);
      chk("vdot_rst_elem", elem_idx, 0);
      chk("vdot_rst_s_en", s_en, 0);
      chk("vdot_rst_dst", dst_addr, 0);
      chk("vdot_rst_func", functype, 0);
      chk("vdot_rst_busy", busy, 0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("vdot_post_valid", exe_valid, 0);
      end
      chk("vdot_post_ready", instr_ready, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
